// File: rtl/ebus_dev_responder_if.sv
// ebus_dev_responder_if
// EBUS signals shared by one initiator and one device responder.
//   ebusCS      : controller select code (initiator -> responder)
//   ebusFunc    : function code 000 CONO, 001 CONI, 010 DATAO, 011 DATAI
//   ebusDemand  : initiator demand, held until the transfer is seen
//   ebusDataIn  : initiator data (AD path)
//   ebusXfer    : responder transfer acknowledge
//   ebusDriving : responder owns the bus data lines
//   ebusDataOut : responder data, zero whenever ebusDriving is low
// Handshake: a request is presented by holding ebusDemand high with stable
// CS/Func/DataIn; the responder answers with ebusXfer high (and, for reads,
// ebusDriving high with data valid) and holds it until ebusDemand drops.
interface ebus_dev_responder_if;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic [35:0] ebusDataIn;
  logic        ebusXfer;
  logic        ebusDriving;
  logic [35:0] ebusDataOut;

  modport master (
    output ebusCS, ebusFunc, ebusDemand, ebusDataIn,
    input  ebusXfer, ebusDriving, ebusDataOut
  );

  modport slave (
    input  ebusCS, ebusFunc, ebusDemand, ebusDataIn,
    output ebusXfer, ebusDriving, ebusDataOut
  );
endinterface

// File: rtl/ebus_dev_responder.sv
// ebus_dev_responder
// EBUS device-side responder: decodes CONO/CONI/DATAO/DATAI addressed to
// DEV_ID, keeps the device control register and hands data words to and from
// the device.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   ebus        : EBUS slave modport (see ebus_dev_responder_if)
//   conReg      : control register; bit 17 (PDP-10 bit 18) is the sticky
//                 DATAI-timeout error, cleared by writing 1 through CONO
//   dataoValid  : one-cycle strobe with dataoWord
//   dataoWord   : last word written by DATAO
//   dataiWord   : device word returned by DATAI
//   dataiReady  : dataiWord is valid
//   dbg_state   : current FSM state encoding
// Bus data uses PDP-10 numbering: word bit 0 is the MSB, so word bits 18..35
// are the low 18 bits ([17:0]) of the vectors here.
module ebus_dev_responder #(
  parameter logic [6:0] DEV_ID        = 7'o040,
  parameter int unsigned DATAI_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  ebus_dev_responder_if.slave        ebus,
  output logic [17:0]                conReg,
  output logic                       dataoValid,
  output logic [35:0]                dataoWord,
  input  logic [35:0]                dataiWord,
  input  logic                       dataiReady,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    WAITDEV = 3'd2,
    XFER    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [1:0] FN_CONO  = 2'b00;
  localparam logic [1:0] FN_CONI  = 2'b01;
  localparam logic [1:0] FN_DATAO = 2'b10;
  localparam logic [1:0] FN_DATAI = 2'b11;

  state_t      state, state_next;
  logic [1:0]  func_q;
  logic [35:0] data_q;
  logic [35:0] hold_q;
  logic [7:0]  cnt_q;
  logic        accept;
  logic        busy;
  logic        timeout_hit;
  logic        xfer_next;
  logic        drive_next;

  assign accept      = ebus.ebusDemand && (ebus.ebusCS == DEV_ID) && !ebus.ebusFunc[2];
  assign busy        = (state != IDLE);
  // The decrement in this cycle would bring the counter to zero.
  assign timeout_hit = (cnt_q <= 8'd1);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCEPT;
      ACCEPT: begin
        if (!ebus.ebusDemand)        state_next = RELEASE;
        else if (func_q == FN_DATAI) state_next = WAITDEV;
        else                         state_next = XFER;
      end
      WAITDEV: begin
        if (!ebus.ebusDemand)             state_next = RELEASE;
        else if (dataiReady || timeout_hit) state_next = XFER;
      end
      XFER:    if (!ebus.ebusDemand) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe. CONI and DATAI (func bit 0 set) drive data.
  assign xfer_next  = (state_next == XFER);
  assign drive_next = xfer_next && func_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      func_q           <= FN_CONO;
      data_q           <= '0;
      hold_q           <= '0;
      cnt_q            <= '0;
      conReg           <= '0;
      dataoWord        <= '0;
      dataoValid       <= 1'b0;
      ebus.ebusXfer    <= 1'b0;
      ebus.ebusDriving <= 1'b0;
    end else begin
      dataoValid       <= 1'b0;
      ebus.ebusXfer    <= xfer_next;
      ebus.ebusDriving <= drive_next;
      case (state)
        IDLE: begin
          if (accept) begin
            func_q <= ebus.ebusFunc[1:0];
            data_q <= ebus.ebusDataIn;
          end
        end
        // ACCEPT side effects apply even when the demand drops this cycle.
        ACCEPT: begin
          case (func_q)
            FN_CONO:  conReg <= {conReg[17] & ~data_q[17], data_q[16:0]};
            FN_CONI:  hold_q <= {17'b0, busy, conReg};
            FN_DATAO: begin
              dataoWord  <= data_q;
              dataoValid <= 1'b1;
            end
            default:  cnt_q <= 8'(DATAI_TIMEOUT);
          endcase
        end
        WAITDEV: begin
          if (ebus.ebusDemand) begin
            if (dataiReady) begin
              hold_q <= dataiWord;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (timeout_hit) begin
                hold_q     <= '0;
                conReg[17] <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ebus.ebusDataOut = ebus.ebusDriving ? hold_q : 36'b0;

endmodule

// File: tb/tb_ebus_dev_responder.sv
// tb_ebus_dev_responder
// Directed bench for ebus_dev_responder with default parameters
// (DEV_ID = 7'o040, DATAI_TIMEOUT = 15). Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point.
module tb_ebus_dev_responder;

  localparam logic [6:0] DEV = 7'o040;
  localparam logic [6:0] NON = 7'o041;
  localparam logic [35:0] LOOP_W = 36'o123456_654321;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] conReg;
  logic        dataoValid;
  logic [35:0] dataoWord;
  logic [35:0] dataiWord;
  logic        dataiReady;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  ebus_dev_responder_if bus();

  ebus_dev_responder dut (
    .clk        (clk),
    .reset      (reset),
    .ebus       (bus),
    .conReg     (conReg),
    .dataoValid (dataoValid),
    .dataoWord  (dataoWord),
    .dataiWord  (dataiWord),
    .dataiReady (dataiReady),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle;
    bus.ebusDemand = 1'b0;
    bus.ebusCS     = 7'o0;
    bus.ebusFunc   = 3'b000;
    bus.ebusDataIn = 36'b0;
  endtask

  task automatic start(input logic [6:0] cs, input logic [2:0] fn, input logic [35:0] d);
    bus.ebusCS     = cs;
    bus.ebusFunc   = fn;
    bus.ebusDataIn = d;
    bus.ebusDemand = 1'b1;
  endtask

  // Drop demand and let XFER -> RELEASE -> IDLE complete.
  task automatic finish_xact;
    bus_idle();
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL reset_xfer got=%b exp=0", bus.ebusXfer); end
    checks++; if (bus.ebusDriving !== 1'b0) begin failures++; $display("FAIL reset_driving got=%b exp=0", bus.ebusDriving); end
    checks++; if (bus.ebusDataOut !== 36'b0) begin failures++; $display("FAIL reset_dataout got=%o exp=0", bus.ebusDataOut); end
    checks++; if (conReg !== 18'b0) begin failures++; $display("FAIL reset_conreg got=%o exp=0", conReg); end
    checks++; if (dataoValid !== 1'b0) begin failures++; $display("FAIL reset_dataovalid got=%b exp=0", dataoValid); end
    checks++; if (dataoWord !== 36'b0) begin failures++; $display("FAIL reset_dataoword got=%o exp=0", dataoWord); end
  endtask

  task automatic test_cono;
    start(DEV, 3'b000, 36'o000000_777777);
    tick();  // accepted, now ACCEPT
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL cono_xfer_n1 got=%b exp=0", bus.ebusXfer); end
    // Selector and function changes after acceptance must not matter.
    bus.ebusCS   = NON;
    bus.ebusFunc = 3'b100;
    tick();
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL cono_xfer_n2 got=%b exp=1", bus.ebusXfer); end
    checks++; if (conReg !== 18'o377777) begin failures++; $display("FAIL cono_conreg got=%o exp=377777", conReg); end
    checks++; if (bus.ebusDriving !== 1'b0) begin failures++; $display("FAIL cono_driving got=%b exp=0", bus.ebusDriving); end
    tick();
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL cono_xfer_hold got=%b exp=1", bus.ebusXfer); end
    bus_idle();
    tick();
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL cono_xfer_drop got=%b exp=0", bus.ebusXfer); end
    tick();
  endtask

  task automatic test_coni;
    start(DEV, 3'b000, 36'o000000_000005);
    tick();
    tick();
    finish_xact();
    checks++; if (conReg !== 18'o000005) begin failures++; $display("FAIL coni_setup_conreg got=%o exp=000005", conReg); end
    start(DEV, 3'b001, 36'b0);
    tick();
    tick();
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL coni_xfer got=%b exp=1", bus.ebusXfer); end
    checks++; if (bus.ebusDriving !== 1'b1) begin failures++; $display("FAIL coni_driving got=%b exp=1", bus.ebusDriving); end
    checks++; if (bus.ebusDataOut !== 36'o000001_000005) begin failures++; $display("FAIL coni_data got=%o exp=000001000005", bus.ebusDataOut); end
    bus_idle();
    tick();
    checks++; if (bus.ebusDataOut !== 36'b0) begin failures++; $display("FAIL coni_data_release got=%o exp=0", bus.ebusDataOut); end
    tick();
  endtask

  task automatic test_loopback;
    start(DEV, 3'b010, LOOP_W);
    tick();
    checks++; if (dataoValid !== 1'b0) begin failures++; $display("FAIL datao_valid_early got=%b exp=0", dataoValid); end
    tick();
    checks++; if (dataoValid !== 1'b1) begin failures++; $display("FAIL datao_valid got=%b exp=1", dataoValid); end
    checks++; if (dataoWord !== LOOP_W) begin failures++; $display("FAIL datao_word got=%o exp=%o", dataoWord, LOOP_W); end
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL datao_xfer got=%b exp=1", bus.ebusXfer); end
    tick();
    checks++; if (dataoValid !== 1'b0) begin failures++; $display("FAIL datao_single_pulse got=%b exp=0", dataoValid); end
    finish_xact();
    dataiWord  = LOOP_W;
    dataiReady = 1'b0;
    start(DEV, 3'b011, 36'b0);
    tick();  // ACCEPT
    tick();  // WAITDEV cycle 1
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL datai_xfer_wait got=%b exp=0", bus.ebusXfer); end
    tick();  // WAITDEV cycle 2
    tick();  // WAITDEV cycle 3
    dataiReady = 1'b1;
    tick();
    dataiReady = 1'b0;
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL datai_xfer got=%b exp=1", bus.ebusXfer); end
    checks++; if (bus.ebusDriving !== 1'b1) begin failures++; $display("FAIL datai_driving got=%b exp=1", bus.ebusDriving); end
    checks++; if (bus.ebusDataOut !== LOOP_W) begin failures++; $display("FAIL datai_data got=%o exp=%o", bus.ebusDataOut, LOOP_W); end
    checks++; if (conReg !== 18'o000005) begin failures++; $display("FAIL datai_no_error got=%o exp=000005", conReg); end
    finish_xact();
  endtask

  task automatic test_timeout;
    int n;
    logic seen;
    dataiReady = 1'b0;
    dataiWord  = 36'o777777_777777;
    seen = 1'b0;
    n = 0;
    start(DEV, 3'b011, 36'b0);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (bus.ebusXfer === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL timeout_xfer_seen got=0 exp=1"); end
    checks++; if (n != 17) begin failures++; $display("FAIL timeout_latency got=%0d exp=17", n); end
    checks++; if (bus.ebusDataOut !== 36'b0) begin failures++; $display("FAIL timeout_data got=%o exp=0", bus.ebusDataOut); end
    checks++; if (conReg !== 18'o400005) begin failures++; $display("FAIL timeout_conreg got=%o exp=400005", conReg); end
    finish_xact();
    start(DEV, 3'b000, 36'o000000_400000);
    tick();
    tick();
    checks++; if (conReg !== 18'o000000) begin failures++; $display("FAIL w1c_clear got=%o exp=0", conReg); end
    finish_xact();
  endtask

  // Ready arriving in the last allowed WAITDEV cycle beats the timeout.
  task automatic test_timeout_edge;
    dataiReady = 1'b0;
    dataiWord  = 36'o252525_525252;
    start(DEV, 3'b011, 36'b0);
    tick();  // ACCEPT
    for (int i = 0; i < 15; i++) tick();  // now in WAITDEV cycle 15
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL edge_xfer_wait got=%b exp=0", bus.ebusXfer); end
    dataiReady = 1'b1;
    tick();
    dataiReady = 1'b0;
    checks++; if (bus.ebusDataOut !== 36'o252525_525252) begin failures++; $display("FAIL edge_data got=%o exp=252525525252", bus.ebusDataOut); end
    checks++; if (conReg[17] !== 1'b0) begin failures++; $display("FAIL edge_no_error got=%b exp=0", conReg[17]); end
    finish_xact();
  endtask

  task automatic test_nonmatch;
    logic bad;
    bad = 1'b0;
    start(NON, 3'b000, 36'o000000_000777);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ebusXfer !== 1'b0 || bus.ebusDriving !== 1'b0) bad = 1'b1;
    end
    start(DEV, 3'b100, 36'o000000_000777);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ebusXfer !== 1'b0 || bus.ebusDriving !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL nonmatch_quiet got=%b exp=0", bad); end
    checks++; if (conReg !== 18'o000000) begin failures++; $display("FAIL nonmatch_conreg got=%o exp=0", conReg); end
    bus_idle();
    tick();
  endtask

  // Demand reasserted during RELEASE waits for IDLE: one extra cycle.
  task automatic test_back_to_back;
    start(DEV, 3'b000, 36'o000000_000012);
    tick();
    tick();
    bus_idle();
    tick();  // RELEASE
    start(DEV, 3'b000, 36'o000000_000034);
    tick();  // IDLE (demand ignored in RELEASE)
    tick();  // ACCEPT
    checks++; if (bus.ebusXfer !== 1'b0) begin failures++; $display("FAIL b2b_xfer_early got=%b exp=0", bus.ebusXfer); end
    checks++; if (conReg !== 18'o000012) begin failures++; $display("FAIL b2b_conreg_first got=%o exp=000012", conReg); end
    tick();
    checks++; if (bus.ebusXfer !== 1'b1) begin failures++; $display("FAIL b2b_xfer got=%b exp=1", bus.ebusXfer); end
    checks++; if (conReg !== 18'o000034) begin failures++; $display("FAIL b2b_conreg_second got=%o exp=000034", conReg); end
    finish_xact();
  endtask

  task automatic test_abort_waitdev;
    logic seen;
    seen = 1'b0;
    dataiReady = 1'b0;
    start(DEV, 3'b011, 36'b0);
    tick();
    tick();
    tick();
    if (bus.ebusXfer !== 1'b0) seen = 1'b1;
    bus_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ebusXfer !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_xfer got=%b exp=0", seen); end
    checks++; if (conReg !== 18'o000034) begin failures++; $display("FAIL abort_conreg got=%o exp=000034", conReg); end
  endtask

  task automatic test_reset_mid;
    dataiReady = 1'b0;
    start(DEV, 3'b011, 36'b0);
    tick();
    tick();
    tick();  // in WAITDEV
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_idle();
    checks++; if ({bus.ebusXfer, bus.ebusDriving, dataoValid} !== 3'b000) begin failures++; $display("FAIL rst_wait_ctl got=%b exp=000", {bus.ebusXfer, bus.ebusDriving, dataoValid}); end
    checks++; if (bus.ebusDataOut !== 36'b0) begin failures++; $display("FAIL rst_wait_data got=%o exp=0", bus.ebusDataOut); end
    checks++; if (conReg !== 18'b0) begin failures++; $display("FAIL rst_wait_conreg got=%o exp=0", conReg); end
    tick();
    // Reset while a DATAO sits in ACCEPT: no strobe, no word.
    start(DEV, 3'b010, 36'o111111_222222);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_idle();
    checks++; if (dataoValid !== 1'b0) begin failures++; $display("FAIL rst_accept_valid got=%b exp=0", dataoValid); end
    checks++; if (dataoWord !== 36'b0) begin failures++; $display("FAIL rst_accept_word got=%o exp=0", dataoWord); end
    tick();
    checks++; if (dataoValid !== 1'b0) begin failures++; $display("FAIL rst_accept_valid_after got=%b exp=0", dataoValid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset      = 1'b1;
    dataiWord  = 36'b0;
    dataiReady = 1'b0;
    bus_idle();
    test_reset();
    test_cono();
    test_coni();
    test_loopback();
    test_timeout();
    test_timeout_edge();
    test_nonmatch();
    test_back_to_back();
    test_abort_waitdev();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ebus_dev_responder.md
EBUS_DEV_RESPONDER -- requirements
Module: ebus_dev_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'o040, the EBUS controller select code this device answers to.
REQ-002 SHALL have parameter DATAI_TIMEOUT, default 15, the maximum number of cycles to wait for dataiReady (range 1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ebusCS  input  7  controller select.
REQ-006 SHALL have port ebusFunc  input  3  function code: 000 CONO, 001 CONI, 010 DATAO, 011 DATAI, 1xx ignored.
REQ-007 SHALL have port ebusDemand  input  1  initiator demand, held until transfer is seen.
REQ-008 SHALL have port ebusDataIn  input  36  bus data driven by the initiator (AD path).
REQ-009 SHALL have port ebusXfer  output  1  responder transfer acknowledge.
REQ-010 SHALL have port ebusDriving  output  1  responder owns the bus data lines.
REQ-011 SHALL have port ebusDataOut  output  36  responder data; zero whenever ebusDriving=0.
REQ-012 SHALL have port conReg  output  18  device control register, loaded by CONO from ebusDataIn[18:35].
REQ-013 SHALL have port dataoValid  output  1  one-cycle strobe accompanying dataoWord.
REQ-014 SHALL have port dataoWord  output  36  word captured by DATAO.
REQ-015 SHALL have port dataiWord  input  36  device word returned by DATAI.
REQ-016 SHALL have port dataiReady  input  1  dataiWord is valid.

Function
REQ-017 SHALL implement FSM states IDLE, ACCEPT, WAITDEV, XFER, RELEASE.
REQ-018 IDLE: when ebusDemand=1, ebusCS=DEV_ID and ebusFunc[2]=0, SHALL latch ebusFunc and ebusDataIn and go to ACCEPT next cycle; otherwise SHALL remain in IDLE.
REQ-019 ACCEPT, CONO: SHALL load conReg from latched data[18:35], except bit 18 (write-1-to-clear error) SHALL be cleared when latched data bit 18 = 1 and otherwise keep its value; SHALL go to XFER.
REQ-020 ACCEPT, DATAO: SHALL load dataoWord, pulse dataoValid for exactly this cycle, and go to XFER.
REQ-021 ACCEPT, CONI: SHALL load output holding register with {17'b0, busy, conReg}, where busy=1 whenever FSM is not IDLE; SHALL go to XFER.
REQ-022 ACCEPT, DATAI: SHALL load the timeout counter with DATAI_TIMEOUT and go to WAITDEV.
REQ-023 WAITDEV: on dataiReady=1 SHALL capture dataiWord and go to XFER; otherwise SHALL decrement the counter; if counter reaches 0 while dataiReady=0, SHALL capture 36'b0, set conReg[18] (error), and go to XFER.
REQ-024 dataiReady in the same cycle the counter hits 0 SHALL win: data captured, no error.
REQ-025 XFER: ebusXfer=1; for CONI/DATAI ebusDriving=1 and ebusDataOut=holding register; SHALL stay until ebusDemand=0, then go to RELEASE.
REQ-026 RELEASE: ebusXfer=0, ebusDriving=0 for exactly one cycle, then IDLE; a demand present in RELEASE SHALL be ignored and re-evaluated in IDLE.
REQ-027 Latency: demand accepted at edge N -> ebusXfer high from cycle N+2 for CONO/CONI/DATAO; DATAI adds WAITDEV cycles (min 1).
REQ-028 ebusCS or ebusFunc changes after acceptance SHALL be ignored until the next IDLE.
REQ-029 ebusDemand dropping during ACCEPT or WAITDEV SHALL abort to RELEASE without asserting ebusXfer; register side effects already taken in ACCEPT SHALL stand.
REQ-030 ebusXfer, ebusDriving, dataoValid SHALL be registered outputs, glitch-free.

Reset
REQ-031 reset SHALL force FSM to IDLE, conReg=0, dataoWord=0, holding register=0, counter=0, ebusXfer=0, ebusDriving=0, dataoValid=0, ebusDataOut=0.
REQ-032 reset asserted mid-transaction SHALL abandon it in the next cycle with no dataoValid pulse and no conReg update.

Verification
REQ-033 CONO: CS=DEV_ID, func=000, data=36'o000000_777777, demand -> conReg=18'o377777 (bit 18 W1C on clear reg), ebusXfer at N+2, dropped one cycle after demand falls.
REQ-034 DATAO then DATAI loopback: DATAO 36'o123456_654321 -> single dataoValid with that word; DATAI with dataiReady at 3rd WAITDEV cycle returning same word -> ebusDataOut=36'o123456_654321 while ebusXfer=1.
REQ-035 DATAI timeout: dataiReady held 0, DATAI_TIMEOUT=15 -> ebusDataOut=0, conReg[18]=1; subsequent CONO with bit 18=1 clears it.
REQ-036 Non-match: CS=DEV_ID+1 or func=100 with demand -> no ebusXfer, ebusDriving stays 0 for 20 cycles.
REQ-037 Reset during WAITDEV and abort: reset -> all outputs 0 next cycle; separate run dropping demand in WAITDEV -> RELEASE, ebusXfer never asserted.
REQ-038 CONI: after conReg=18'o000005 -> ebusDataOut=36'o000001_000005 (busy set) during XFER.
